// File: rtl/redraw_scheduler_pkg.sv
// Shared definitions for the redraw scheduler: FSM states, redraw causes,
// board geometry and frame timing constants.
package redraw_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_DRAW  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_CURSOR = 2'd0,
    CAUSE_PLACE  = 2'd1,
    CAUSE_GUESS  = 2'd2,
    CAUSE_FULL   = 2'd3
  } cause_t;

  localparam int BOARD_CELLS  = 100;
  localparam int CELL_PIXELS  = 64;
  localparam int TOTAL_CELLS  = 2 * BOARD_CELLS;
  localparam int DRAIN_CYCLES = 70;
  localparam int MAX_CYCLES   = 20000;
  localparam int WD_WIDTH     = 15;
  localparam int DRAIN_WIDTH  = 7;

  // Request vector bit order: [0]=cursor, [1]=place, [2]=guess, [3]=full.
  function automatic cause_t encode_cause(input logic [3:0] req);
    if (req[3]) return CAUSE_FULL;
    else if (req[2]) return CAUSE_GUESS;
    else if (req[1]) return CAUSE_PLACE;
    else return CAUSE_CURSOR;
  endfunction

endpackage

// File: rtl/redraw_request_latch.sv
// Holds one pending bit per redraw request source and priority-encodes the
// combined pending/live requests into a cause code.
module redraw_request_latch
  import redraw_scheduler_pkg::*;
(
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [3:0] req,
  input  logic       clear,
  output logic       any_req,
  output cause_t     cause
);

  logic [3:0] pending;
  logic [3:0] merged;

  assign merged  = pending | req;
  assign any_req = |merged;
  assign cause   = encode_cause(merged);

  // A request arriving in the clearing cycle survives so it earns its own frame.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      pending <= 4'b0;
    end else begin
      pending <= (clear ? 4'b0 : pending) | req;
    end
  end

endmodule

// File: rtl/redraw_scheduler.sv
// Sequences full-screen redraws of both boards: snapshots the cursor/turn
// inputs per frame, runs the datapath until all cells drain, and watchdogs it.
module redraw_scheduler
  import redraw_scheduler_pkg::*;
#(
  parameter int TOTAL_CELLS_P  = TOTAL_CELLS,
  parameter int DRAIN_CYCLES_P = DRAIN_CYCLES,
  parameter int MAX_CYCLES_P   = MAX_CYCLES
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       REQ_CURSOR,
  input  logic       REQ_PLACE,
  input  logic       REQ_GUESS,
  input  logic       REQ_FULL,
  input  logic [3:0] x_req,
  input  logic [3:0] y_req,
  input  logic       rotate_req,
  input  logic       player1_move_req,
  input  logic [7:0] board_counter,
  output logic       START_DRAWING,
  output logic       PLOT,
  output logic [3:0] x_out,
  output logic [3:0] y_out,
  output logic       rotate_out,
  output logic       player1_move_out,
  output logic       BUSY,
  output logic       FRAME_DONE,
  output logic [1:0] last_cause,
  output logic [7:0] frame_count,
  output logic       TIMEOUT
);

  localparam logic [7:0]             CELLS_LIMIT = 8'(TOTAL_CELLS_P);
  localparam logic [DRAIN_WIDTH-1:0] DRAIN_LOAD  = DRAIN_WIDTH'(DRAIN_CYCLES_P - 1);
  localparam logic [WD_WIDTH-1:0]    WD_LIMIT    = WD_WIDTH'(MAX_CYCLES_P - 1);

  state_t                 state_q, state_d;
  logic [DRAIN_WIDTH-1:0] drain_q;
  logic [WD_WIDTH-1:0]    wd_q;
  logic                   abort_q;
  cause_t                 cause_q;
  cause_t                 cause_now;
  logic                   any_req;
  logic                   clear_pending;
  logic                   wd_expired;
  logic                   cells_done;
  logic [3:0]             x_q, y_q;
  logic                   rotate_q, player1_q;
  logic [7:0]             frame_count_q;
  logic                   timeout_q;

  redraw_request_latch u_request_latch (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .req     ({REQ_FULL, REQ_GUESS, REQ_PLACE, REQ_CURSOR}),
    .clear   (clear_pending),
    .any_req (any_req),
    .cause   (cause_now)
  );

  assign wd_expired = (wd_q == WD_LIMIT);
  assign cells_done = (board_counter >= CELLS_LIMIT);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    START_DRAWING = 1'b1;
    PLOT          = 1'b0;
    BUSY          = 1'b0;
    FRAME_DONE    = 1'b0;
    clear_pending = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_LATCH;
      end
      S_LATCH: begin
        BUSY          = 1'b1;
        clear_pending = 1'b1;
        state_d       = S_DRAW;
      end
      S_DRAW: begin
        START_DRAWING = 1'b0;
        PLOT          = 1'b1;
        BUSY          = 1'b1;
        if (wd_expired) state_d = S_DONE;
        else if (cells_done) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        START_DRAWING = 1'b0;
        PLOT          = 1'b1;
        BUSY          = 1'b1;
        if (wd_expired || drain_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        BUSY       = 1'b1;
        FRAME_DONE = !abort_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Watchdog expiry marks the frame aborted so DONE suppresses its pulse and count.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      drain_q       <= '0;
      wd_q          <= '0;
      abort_q       <= 1'b0;
      cause_q       <= CAUSE_CURSOR;
      x_q           <= 4'd0;
      y_q           <= 4'd0;
      rotate_q      <= 1'b0;
      player1_q     <= 1'b0;
      frame_count_q <= 8'd0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        S_LATCH: begin
          x_q       <= x_req;
          y_q       <= y_req;
          rotate_q  <= rotate_req;
          player1_q <= player1_move_req;
          cause_q   <= cause_now;
          wd_q      <= '0;
          abort_q   <= 1'b0;
        end
        S_DRAW: begin
          wd_q <= wd_q + 1'b1;
          if (wd_expired) begin
            timeout_q <= 1'b1;
            abort_q   <= 1'b1;
          end else if (cells_done) begin
            drain_q <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          wd_q <= wd_q + 1'b1;
          if (wd_expired) begin
            timeout_q <= 1'b1;
            abort_q   <= 1'b1;
          end else if (drain_q != '0) begin
            drain_q <= drain_q - 1'b1;
          end
        end
        S_DONE: begin
          if (!abort_q) frame_count_q <= frame_count_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign x_out            = x_q;
  assign y_out            = y_q;
  assign rotate_out       = rotate_q;
  assign player1_move_out = player1_q;
  assign last_cause       = cause_q;
  assign frame_count      = frame_count_q;
  assign TIMEOUT          = timeout_q;

endmodule

// File: tb/tb_redraw_scheduler.sv
// Directed self-checking bench for redraw_scheduler: latency, snapshotting,
// request coalescing, drain length, watchdog, async reset and counter wrap.
module tb_redraw_scheduler;

  logic       CLOCK;
  logic       RESET;
  logic       REQ_CURSOR, REQ_PLACE, REQ_GUESS, REQ_FULL;
  logic [3:0] x_req, y_req;
  logic       rotate_req, player1_move_req;
  logic [7:0] board_counter;
  logic       START_DRAWING, PLOT;
  logic [3:0] x_out, y_out;
  logic       rotate_out, player1_move_out;
  logic       BUSY, FRAME_DONE;
  logic [1:0] last_cause;
  logic [7:0] frame_count;
  logic       TIMEOUT;

  int total = 0;
  int bad   = 0;

  redraw_scheduler dut (
    .CLOCK            (CLOCK),
    .RESET            (RESET),
    .REQ_CURSOR       (REQ_CURSOR),
    .REQ_PLACE        (REQ_PLACE),
    .REQ_GUESS        (REQ_GUESS),
    .REQ_FULL         (REQ_FULL),
    .x_req            (x_req),
    .y_req            (y_req),
    .rotate_req       (rotate_req),
    .player1_move_req (player1_move_req),
    .board_counter    (board_counter),
    .START_DRAWING    (START_DRAWING),
    .PLOT             (PLOT),
    .x_out            (x_out),
    .y_out            (y_out),
    .rotate_out       (rotate_out),
    .player1_move_out (player1_move_out),
    .BUSY             (BUSY),
    .FRAME_DONE       (FRAME_DONE),
    .last_cause       (last_cause),
    .frame_count      (frame_count),
    .TIMEOUT          (TIMEOUT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  // Completes a frame already in DRAW; returns edges until FRAME_DONE was seen.
  task automatic finish_frame(output int n, output logic sd_at_done, output logic fd_after);
    board_counter = 8'd200;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (FRAME_DONE) break;
    end
    sd_at_done    = START_DRAWING;
    board_counter = 8'd0;
    tick();
    fd_after = FRAME_DONE;
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    {REQ_CURSOR, REQ_PLACE, REQ_GUESS, REQ_FULL} = 4'b0;
    x_req = 4'd0; y_req = 4'd0; rotate_req = 1'b0; player1_move_req = 1'b0;
    board_counter = 8'd0;
    #22;
    total++;
    if ({START_DRAWING, PLOT, BUSY, FRAME_DONE, TIMEOUT} !== 5'b10000) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got SD/PLOT/BUSY/FD/TO=%b expected 10000",
               {START_DRAWING, PLOT, BUSY, FRAME_DONE, TIMEOUT});
    end
    total++;
    if ({x_out, y_out, rotate_out, player1_move_out, last_cause, frame_count} !== 20'd0) begin
      bad++;
      $display("[TB] FAIL reset_latched: got x=%0d y=%0d rot=%b p1=%b cause=%0d fc=%0d expected all 0",
               x_out, y_out, rotate_out, player1_move_out, last_cause, frame_count);
    end
    @(negedge CLOCK);
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_latency;
    x_req = 4'd3; y_req = 4'd7; rotate_req = 1'b1; player1_move_req = 1'b1;
    REQ_CURSOR = 1'b1;
    tick();
    REQ_CURSOR = 1'b0;
    total++;
    if (BUSY !== 1'b1 || START_DRAWING !== 1'b1 || x_out !== 4'd0) begin
      bad++;
      $display("[TB] FAIL latch_cycle: got busy=%b sd=%b x=%0d expected busy=1 sd=1 x=0",
               BUSY, START_DRAWING, x_out);
    end
    tick();
    total++;
    if (START_DRAWING !== 1'b0 || PLOT !== 1'b1) begin
      bad++;
      $display("[TB] FAIL draw_start: got sd=%b plot=%b expected sd=0 plot=1", START_DRAWING, PLOT);
    end
    total++;
    if (x_out !== 4'd3 || y_out !== 4'd7 || rotate_out !== 1'b1 || player1_move_out !== 1'b1
        || last_cause !== 2'd0) begin
      bad++;
      $display("[TB] FAIL snapshot: got x=%0d y=%0d rot=%b p1=%b cause=%0d expected 3 7 1 1 0",
               x_out, y_out, rotate_out, player1_move_out, last_cause);
    end
  endtask

  task automatic test_hold_and_coalesce;
    int   n;
    logic sd, fd;
    int   busy_seen;
    x_req = 4'd9;
    REQ_GUESS = 1'b1;
    tick();
    REQ_GUESS = 1'b0; REQ_CURSOR = 1'b1;
    tick();
    REQ_GUESS = 1'b1;
    tick();
    REQ_CURSOR = 1'b0; REQ_GUESS = 1'b0;
    tick();
    total++;
    if (x_out !== 4'd3) begin
      bad++;
      $display("[TB] FAIL x_hold: got x_out=%0d expected 3", x_out);
    end
    finish_frame(n, sd, fd);
    total++;
    if (n !== 71) begin
      bad++;
      $display("[TB] FAIL drain_len: got %0d edges to FRAME_DONE expected 71", n);
    end
    total++;
    if (sd !== 1'b1 || fd !== 1'b0 || frame_count !== 8'd1) begin
      bad++;
      $display("[TB] FAIL frame1_done: got sd=%b fd_next=%b fc=%0d expected 1 0 1", sd, fd, frame_count);
    end
    total++;
    if (BUSY !== 1'b0 || START_DRAWING !== 1'b1) begin
      bad++;
      $display("[TB] FAIL gap_idle: got busy=%b sd=%b expected 0 1", BUSY, START_DRAWING);
    end
    tick();
    total++;
    if (BUSY !== 1'b1 || START_DRAWING !== 1'b1) begin
      bad++;
      $display("[TB] FAIL followup_latch: got busy=%b sd=%b expected 1 1", BUSY, START_DRAWING);
    end
    REQ_CURSOR = 1'b1;
    tick();
    REQ_CURSOR = 1'b0;
    total++;
    if (last_cause !== 2'd2 || x_out !== 4'd9) begin
      bad++;
      $display("[TB] FAIL frame2_snapshot: got cause=%0d x=%0d expected 2 9", last_cause, x_out);
    end
    finish_frame(n, sd, fd);
    total++;
    if (n !== 71 || frame_count !== 8'd2) begin
      bad++;
      $display("[TB] FAIL frame2_done: got n=%0d fc=%0d expected 71 2", n, frame_count);
    end
    tick();
    tick();
    total++;
    if (last_cause !== 2'd0 || START_DRAWING !== 1'b0) begin
      bad++;
      $display("[TB] FAIL survivor_frame: got cause=%0d sd=%b expected 0 0", last_cause, START_DRAWING);
    end
    finish_frame(n, sd, fd);
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (BUSY) busy_seen++;
    end
    total++;
    if (busy_seen !== 0 || frame_count !== 8'd3) begin
      bad++;
      $display("[TB] FAIL coalesce_once: got busy_cycles=%0d fc=%0d expected 0 3", busy_seen, frame_count);
    end
  endtask

  task automatic test_timeout;
    int   n;
    int   fd_seen;
    logic sd, fd;
    REQ_PLACE = 1'b1;
    tick();
    REQ_PLACE = 1'b0;
    board_counter = 8'd50;
    n = 0;
    fd_seen = 0;
    for (int i = 0; i < 21000; i++) begin
      tick();
      n++;
      if (FRAME_DONE) fd_seen++;
      if (TIMEOUT) break;
    end
    total++;
    if (TIMEOUT !== 1'b1 || n < 19995 || n > 20005) begin
      bad++;
      $display("[TB] FAIL watchdog: got timeout=%b after %0d edges expected 1 near 20001", TIMEOUT, n);
    end
    total++;
    if (fd_seen !== 0 || frame_count !== 8'd3 || last_cause !== 2'd1) begin
      bad++;
      $display("[TB] FAIL watchdog_abort: got fd_pulses=%0d fc=%0d cause=%0d expected 0 3 1",
               fd_seen, frame_count, last_cause);
    end
    board_counter = 8'd0;
    tick();
    total++;
    if (BUSY !== 1'b0 || START_DRAWING !== 1'b1 || PLOT !== 1'b0 || FRAME_DONE !== 1'b0) begin
      bad++;
      $display("[TB] FAIL watchdog_idle: got busy=%b sd=%b plot=%b fd=%b expected 0 1 0 0",
               BUSY, START_DRAWING, PLOT, FRAME_DONE);
    end
    REQ_CURSOR = 1'b1;
    tick();
    REQ_CURSOR = 1'b0;
    tick();
    finish_frame(n, sd, fd);
    total++;
    if (TIMEOUT !== 1'b1 || frame_count !== 8'd4) begin
      bad++;
      $display("[TB] FAIL timeout_sticky: got timeout=%b fc=%0d expected 1 4", TIMEOUT, frame_count);
    end
  endtask

  task automatic test_reset_mid_drain;
    int fd_seen;
    REQ_FULL = 1'b1;
    tick();
    REQ_FULL = 1'b0;
    tick();
    total++;
    if (last_cause !== 2'd3) begin
      bad++;
      $display("[TB] FAIL full_cause: got cause=%0d expected 3", last_cause);
    end
    board_counter = 8'd200;
    repeat (11) tick();
    #2;
    RESET = 1'b0;
    #1;
    total++;
    if ({START_DRAWING, PLOT, BUSY, FRAME_DONE, TIMEOUT} !== 5'b10000
        || frame_count !== 8'd0 || last_cause !== 2'd0 || x_out !== 4'd0) begin
      bad++;
      $display("[TB] FAIL async_reset: got SD/PLOT/BUSY/FD/TO=%b fc=%0d cause=%0d x=%0d expected 10000 0 0 0",
               {START_DRAWING, PLOT, BUSY, FRAME_DONE, TIMEOUT}, frame_count, last_cause, x_out);
    end
    board_counter = 8'd0;
    fd_seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (FRAME_DONE || BUSY) fd_seen++;
    end
    @(negedge CLOCK);
    RESET = 1'b1;
    tick();
    if (FRAME_DONE || BUSY) fd_seen++;
    total++;
    if (fd_seen !== 0) begin
      bad++;
      $display("[TB] FAIL reset_no_frame: got %0d cycles with FRAME_DONE/BUSY expected 0", fd_seen);
    end
  endtask

  task automatic test_wrap;
    int   n;
    logic sd, fd;
    for (int f = 0; f < 255; f++) begin
      REQ_CURSOR = 1'b1;
      tick();
      REQ_CURSOR = 1'b0;
      tick();
      finish_frame(n, sd, fd);
    end
    total++;
    if (frame_count !== 8'd255) begin
      bad++;
      $display("[TB] FAIL count_255: got fc=%0d expected 255", frame_count);
    end
    REQ_PLACE = 1'b1;
    tick();
    REQ_PLACE = 1'b0;
    tick();
    finish_frame(n, sd, fd);
    total++;
    if (frame_count !== 8'd0 || n !== 71) begin
      bad++;
      $display("[TB] FAIL count_wrap: got fc=%0d n=%0d expected 0 71", frame_count, n);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hold_and_coalesce();
    test_timeout();
    test_reset_mid_drain();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
